// File: rtl/mvm_pkg.sv
`default_nettype none
// =====================================================================
// Package : mvm_pkg
// Shared sizes, controller state encoding and element-offset helper.
// Rev     : 1.0
// =====================================================================
package mvm_pkg;

    localparam int unsigned N_DEF      = 64;
    localparam int unsigned ELEM_W_DEF = 16;
    localparam int unsigned LANES_DEF  = 4;

    typedef enum logic [2:0] {
        LD_VEC = 3'd0,
        LD_MAT = 3'd1,
        RUN    = 3'd2,
        CLEAR  = 3'd3,
        UNLOAD = 3'd4
    } state_t;

    // Element 0 occupies the most-significant slot of an n-element packed vector.
    function automatic int unsigned elem_off(input int unsigned n, input int unsigned w,
                                             input int unsigned k);
        return (n - 1 - k) * w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mvm_result_serializer.sv
`default_nettype none
// =====================================================================
// Module : mvm_result_serializer
// Parallel-load result register drained LANES elements per handshake.
// Rev    : 1.0
// =====================================================================
module mvm_result_serializer
    import mvm_pkg::*;
#(
    parameter int unsigned N      = N_DEF,
    parameter int unsigned ELEM_W = ELEM_W_DEF,
    parameter int unsigned LANES  = LANES_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [N*ELEM_W-1:0]       load_data,
    input  logic                      start,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [LANES*ELEM_W-1:0]   m_data,
    output logic                      m_last,
    output logic                      done
);

    localparam int unsigned c_beat_w = LANES * ELEM_W;
    localparam int unsigned c_nb     = N / LANES;
    localparam int unsigned c_cnt_w  = $clog2(c_nb + 1);
    localparam logic [c_cnt_w-1:0] c_pen = c_cnt_w'(c_nb - 2);

    logic [N*ELEM_W-1:0] r_shift;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_valid;
    logic                r_last;

    assign m_valid = r_valid;
    assign m_last  = r_last;
    assign m_data  = r_shift[N*ELEM_W-1 -: c_beat_w];
    assign done    = r_valid & m_ready & r_last;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (load) begin
            r_shift <= load_data;
        end else if (start) begin
            r_valid <= 1'b1;
            r_cnt   <= '0;
            r_last  <= (c_nb == 1) ? 1'b1 : 1'b0;
        end else if (r_valid && m_ready) begin
            if (r_last) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_shift <= r_shift << c_beat_w;
                r_cnt   <= r_cnt + 1'b1;
                r_last  <= (r_cnt == c_pen);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mvm64_stream_feeder.sv
`default_nettype none
// =====================================================================
// Module : mvm64_stream_feeder
// Loads vector/matrix from a beat stream, runs the MVM engine, streams result.
// Rev    : 1.0
// =====================================================================
module mvm64_stream_feeder
    import mvm_pkg::*;
#(
    parameter int unsigned N       = N_DEF,
    parameter int unsigned ELEM_W  = ELEM_W_DEF,
    parameter int unsigned LANES   = LANES_DEF,
    parameter int unsigned TIMEOUT = 8192
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [LANES*ELEM_W-1:0]   s_data,
    output logic                      mvm_en,
    output logic                      mvm_clr,
    output logic [N*ELEM_W-1:0]       mvm_ai,
    output logic [N*N*ELEM_W-1:0]     mvm_matrix,
    input  logic                      mvm_finish,
    input  logic [N*ELEM_W-1:0]       mvm_psum,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [LANES*ELEM_W-1:0]   m_data,
    output logic                      m_last,
    output logic                      busy,
    output logic                      err
);

    localparam int unsigned c_beat_w = LANES * ELEM_W;
    localparam int unsigned c_nb_vec = N / LANES;
    localparam int unsigned c_nb_mat = (N * N) / LANES;
    localparam int unsigned c_cnt_w  = $clog2(c_nb_mat + 1);
    localparam int unsigned c_tmo_w  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned c_ai_aw  = $clog2(N * ELEM_W);
    localparam int unsigned c_mx_aw  = $clog2(N * N * ELEM_W);
    localparam logic [c_cnt_w-1:0] c_vec_last = c_cnt_w'(c_nb_vec - 1);
    localparam logic [c_cnt_w-1:0] c_mat_last = c_cnt_w'(c_nb_mat - 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT - 1);

    state_t                 r_state, w_state_nxt;
    logic [c_cnt_w-1:0]     r_cnt, w_cnt_nxt;
    logic [c_tmo_w-1:0]     r_tmo, w_tmo_nxt;
    logic                   r_s_ready, r_en, r_clr, r_busy, r_err;
    logic [N*ELEM_W-1:0]    r_ai;
    logic [N*N*ELEM_W-1:0]  r_matrix;
    logic                   w_accept, w_vec_wr, w_mat_wr, w_load, w_timeout, w_start, w_done;
    logic [c_ai_aw-1:0]     w_vec_off;
    logic [c_mx_aw-1:0]     w_mat_off;

    assign w_accept   = s_valid & r_s_ready;
    assign s_ready    = r_s_ready;
    assign mvm_en     = r_en;
    assign mvm_clr    = r_clr;
    assign mvm_ai     = r_ai;
    assign mvm_matrix = r_matrix;
    assign busy       = r_busy;
    assign err        = r_err;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_tmo_nxt   = '0;
        w_vec_wr    = 1'b0;
        w_mat_wr    = 1'b0;
        w_load      = 1'b0;
        w_timeout   = 1'b0;
        w_start     = 1'b0;
        // Each beat's slot is anchored on the last element it carries.
        w_vec_off   = c_ai_aw'(elem_off(N, ELEM_W, (32'(r_cnt) + 32'd1) * LANES - 32'd1));
        w_mat_off   = c_mx_aw'(elem_off(N * N, ELEM_W, (32'(r_cnt) + 32'd1) * LANES - 32'd1));
        case (r_state)
            LD_VEC: begin
                w_cnt_nxt = r_cnt;
                if (w_accept) begin
                    w_vec_wr = 1'b1;
                    if (r_cnt == c_vec_last) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = LD_MAT;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            LD_MAT: begin
                w_cnt_nxt = r_cnt;
                if (w_accept) begin
                    w_mat_wr = 1'b1;
                    if (r_cnt == c_mat_last) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = RUN;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            RUN: begin
                if (mvm_finish) begin
                    w_load      = 1'b1;
                    w_state_nxt = CLEAR;
                end else if ((TIMEOUT != 0) && (r_tmo == c_tmo_last)) begin
                    w_load      = 1'b1;
                    w_timeout   = 1'b1;
                    w_state_nxt = CLEAR;
                end else begin
                    w_tmo_nxt = r_tmo + 1'b1;
                end
            end
            CLEAR: begin
                w_start     = 1'b1;
                w_state_nxt = UNLOAD;
            end
            UNLOAD: begin
                if (w_done) begin
                    w_state_nxt = LD_VEC;
                end
            end
            default: w_state_nxt = LD_VEC;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= LD_VEC;
            r_cnt     <= '0;
            r_tmo     <= '0;
            r_ai      <= '0;
            r_matrix  <= '0;
            r_s_ready <= 1'b0;
            r_en      <= 1'b0;
            r_clr     <= 1'b1;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_tmo     <= w_tmo_nxt;
            r_s_ready <= (w_state_nxt == LD_VEC) || (w_state_nxt == LD_MAT);
            r_en      <= (w_state_nxt == RUN);
            r_clr     <= (w_state_nxt == CLEAR);
            r_busy    <= !((w_state_nxt == LD_VEC) && (w_cnt_nxt == '0));
            if (w_timeout) begin
                r_err <= 1'b1;
            end
            if (w_vec_wr) begin
                r_ai[w_vec_off +: c_beat_w] <= s_data;
            end
            if (w_mat_wr) begin
                r_matrix[w_mat_off +: c_beat_w] <= s_data;
            end
        end
    end

    mvm_result_serializer #(
        .N      (N),
        .ELEM_W (ELEM_W),
        .LANES  (LANES)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (w_load),
        .load_data (w_timeout ? '0 : mvm_psum),
        .start     (w_start),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .done      (w_done)
    );

endmodule
`default_nettype wire

// File: tb/tb_mvm64_stream_feeder.sv
`default_nettype none
// Bench for mvm64_stream_feeder: random jobs, engine model, scoreboard of result beats.
module tb_mvm64_stream_feeder;

    localparam int N   = 64;
    localparam int W   = 16;
    localparam int L   = 4;
    localparam int NB  = N / L;
    localparam int NBM = N * N / L;
    localparam int TMO = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                s_valid = 1'b1;
    logic                s_ready;
    logic [L*W-1:0]      s_data = '0;
    logic                mvm_en, mvm_clr;
    logic [N*W-1:0]      mvm_ai;
    logic [N*N*W-1:0]    mvm_matrix;
    logic                mvm_finish = 1'b0;
    logic [N*W-1:0]      mvm_psum = '0;
    logic                m_valid;
    logic                m_ready = 1'b0;
    logic [L*W-1:0]      m_data;
    logic                m_last, busy, err;

    always #5 clk = ~clk;

    mvm64_stream_feeder #(.N(N), .ELEM_W(W), .LANES(L), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .mvm_en(mvm_en), .mvm_clr(mvm_clr), .mvm_ai(mvm_ai), .mvm_matrix(mvm_matrix),
        .mvm_finish(mvm_finish), .mvm_psum(mvm_psum), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last), .busy(busy), .err(err)
    );

    typedef struct packed {
        logic [L*W-1:0] data;
        logic           last;
    } beat_t;

    beat_t   sb[$];
    int      checks = 0;
    int      errors = 0;
    bit      bp = 1'b0;
    bit      eng_hang = 1'b0;
    bit      err_exp = 1'b0;
    shortint vec[N];
    shortint mat[N*N];

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic abort_run(input string name);
        errors++;
        checks++;
        $display("FAIL %s: no handshake within cycle budget", name);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "bench aborted");
    endtask

    // Engine model: computes vector x matrix from the DUT's buses after a random delay.
    initial begin : engine
        int en_run, dly, clr_run, s;
        en_run = 0; dly = 0; clr_run = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                mvm_finish = 1'b0;
                en_run = 0;
                clr_run = 0;
            end else if (mvm_clr) begin
                if (clr_run == 0 && en_run > 0) begin
                    if (eng_hang) begin
                        err_exp = 1'b1;
                        check("timeout_en_cycles", 80'(en_run), 80'(TMO));
                    end
                    check("err_flag", 80'(err), 80'(err_exp));
                end
                clr_run++;
                mvm_finish = 1'b0;
                en_run = 0;
            end else begin
                if (clr_run > 0) begin
                    check("clr_pulse_len", 80'(clr_run), 80'd1);
                    check("mvalid_after_clr", 80'(m_valid), 80'd1);
                    clr_run = 0;
                end
                if (mvm_en) begin
                    en_run++;
                    if (en_run == 1) dly = $urandom_range(0, 8);
                    if (!mvm_finish && !eng_hang && en_run == dly + 1) begin
                        for (int c = 0; c < N; c++) begin
                            s = 0;
                            for (int r = 0; r < N; r++)
                                s += int'($signed(mvm_ai[(N-1-r)*W +: W])) *
                                     int'($signed(mvm_matrix[(N*N-1-(r*N+c))*W +: W]));
                            mvm_psum[(N-1-c)*W +: W] = s[15:0];
                        end
                        mvm_finish = 1'b1;
                    end
                end
            end
        end
    end

    // Monitor: drives m_ready, pops the scoreboard on each accepted beat, checks hold stability.
    initial begin : monitor
        bit             held;
        logic [L*W-1:0] held_data;
        beat_t          e;
        held = 1'b0;
        held_data = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                held = 1'b0;
                m_ready = 1'b0;
            end else begin
                if (held) begin
                    check("hold_valid", 80'(m_valid), 80'd1);
                    check("hold_data", 80'(m_data), 80'(held_data));
                end
                m_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
                held = m_valid && !m_ready;
                held_data = m_data;
                if (m_valid && m_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got %0h while none expected", m_data);
                    end else begin
                        e = sb.pop_front();
                        check("result_beat", 80'({m_data, m_last}), 80'({e.data, e.last}));
                    end
                end
            end
        end
    end

    task automatic send_beat(input logic [L*W-1:0] d);
        int t;
        t = 0;
        if (bp) repeat ($urandom_range(0, 2)) @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        while (!s_ready) begin
            @(negedge clk);
            t++;
            if (t > 5000) abort_run("input_handshake");
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_data  = logic'($urandom) ? 64'hDEAD_BEEF_0BAD_F00D : '0;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b0;
        s_valid = 1'b1;
        repeat (cycles) @(negedge clk);
        check("rst_s_ready", 80'(s_ready), 80'd0);
        check("rst_mvm_clr", 80'(mvm_clr), 80'd1);
        check("rst_mvm_en", 80'(mvm_en), 80'd0);
        check("rst_m_valid", 80'({m_valid, m_last}), 80'd0);
        check("rst_err_busy", 80'({err, busy}), 80'd0);
        rst = 1'b1;
        s_valid = 1'b0;
        err_exp = 1'b0;
        eng_hang = 1'b0;
        sb.delete();
        @(negedge clk);
        check("post_rst_ready_idle", 80'({s_ready, busy, mvm_clr}), 80'b100);
    endtask

    // kind: 0 identity (vector k+1), 1 all-ones, 2 random; abort_at >= 0 resets inside LD_MAT.
    task automatic run_job(input int kind, input bit hang, input int abort_at);
        int      s;
        shortint res[N];
        beat_t   e;
        for (int k = 0; k < N; k++)
            vec[k] = (kind == 0) ? shortint'(k + 1) : (kind == 1) ? 16'sd1 : shortint'($urandom);
        for (int i = 0; i < N*N; i++)
            mat[i] = (kind == 0) ? shortint'((i / N) == (i % N)) :
                     (kind == 1) ? 16'sd1 : shortint'($urandom);
        for (int b = 0; b < NB; b++) begin
            send_beat({vec[b*L], vec[b*L+1], vec[b*L+2], vec[b*L+3]});
            if (b == 0) begin
                check("prev_results_drained", 80'(sb.size()), 80'd0);
                check("busy_after_first_beat", 80'(busy), 80'd1);
                eng_hang = hang;
            end
        end
        for (int b = 0; b < NBM; b++) begin
            if (b == abort_at) begin
                do_reset(3);
                return;
            end
            send_beat({mat[b*L], mat[b*L+1], mat[b*L+2], mat[b*L+3]});
        end
        check("en_one_cycle_after_last_beat", 80'({mvm_en, s_ready}), 80'b10);
        for (int c = 0; c < N; c++) begin
            s = 0;
            for (int r = 0; r < N; r++) s += int'(vec[r]) * int'(mat[r*N+c]);
            res[c] = hang ? 16'sd0 : shortint'(s[15:0]);
        end
        for (int b = 0; b < NB; b++) begin
            e.data = {res[b*L], res[b*L+1], res[b*L+2], res[b*L+3]};
            e.last = (b == NB - 1);
            sb.push_back(e);
        end
    endtask

    initial begin : driver
        int t;
        do_reset(3);
        bp = 1'b0;
        run_job(0, 1'b0, -1);
        bp = 1'b1;
        run_job(1, 1'b0, -1);
        bp = 1'b0;
        run_job(2, 1'b1, -1);
        run_job(2, 1'b0, -1);
        bp = 1'b1;
        run_job(2, 1'b0, 500);
        run_job(2, 1'b0, -1);
        run_job(2, 1'b0, -1);
        run_job(1, 1'b0, -1);
        t = 0;
        while (sb.size() != 0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("scoreboard_drained", 80'(sb.size()), 80'd0);
        repeat (4) @(negedge clk);
        check("idle_at_end", 80'({m_valid, s_ready, busy}), 80'b010);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
